// File: rtl/bpu_pkg.sv
// bpu_pkg: shared branch-predictor types, widths and history helper
package bpu_pkg;

    localparam int BPU_ADDR_W = 6;
    localparam int BPU_HIST_W = 4;

    typedef struct packed {
        logic [BPU_ADDR_W-1:0] addr;
        logic [BPU_HIST_W-1:0] bhr;
        logic                  pred_direct;
    } bpu_entry_t;

    function automatic logic [BPU_HIST_W-1:0] bpu_shift_hist(input logic [BPU_HIST_W-1:0] bhr, input logic dir);
        return {bhr[BPU_HIST_W-2:0], dir};
    endfunction

endpackage

// File: rtl/bht_update_gen_if.sv
// bht_update_gen_if: prediction push, execute resolve and BHT update bundle
interface bht_update_gen_if #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 6,
    parameter int HIST_W = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              stallreq;
    logic              pred_valid;
    logic [ADDR_W-1:0] pred_addr;
    logic [HIST_W-1:0] pred_bhr;
    logic              pred_direct;
    logic              pred_ready;
    logic              ex_valid;
    logic              ex_real_direct;
    logic              update_valid;
    logic [ADDR_W-1:0] update_addr;
    logic [HIST_W-1:0] update_bhr;
    logic              real_direct;
    logic              pred_true;
    logic              pred_flag;
    logic              flush_req;
    logic              underflow;
    logic [CW-1:0]     count;
    logic [15:0]       stat_total;
    logic [15:0]       stat_miss;

    modport master (
        output stallreq, pred_valid, pred_addr, pred_bhr, pred_direct, ex_valid, ex_real_direct,
        input  pred_ready, update_valid, update_addr, update_bhr, real_direct, pred_true, pred_flag,
               flush_req, underflow, count, stat_total, stat_miss
    );

    modport slave (
        input  stallreq, pred_valid, pred_addr, pred_bhr, pred_direct, ex_valid, ex_real_direct,
        output pred_ready, update_valid, update_addr, update_bhr, real_direct, pred_true, pred_flag,
               flush_req, underflow, count, stat_total, stat_miss
    );

endinterface

// File: rtl/bpu_queue_mem.sv
// bpu_queue_mem: prediction queue storage, one write port and a combinational head read
module bpu_queue_mem import bpu_pkg::*; #(
    parameter int  DEPTH = 8,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [PW-1:0] wr_ptr_i,
    input  bpu_entry_t    wdata_i,
    input  logic [PW-1:0] rd_ptr_i,
    output bpu_entry_t    rdata_o
);

    bpu_entry_t mem_q [DEPTH];

    always_ff @(posedge clk)
        if (we_i) mem_q[wr_ptr_i] <= wdata_i;

    assign rdata_o = mem_q[rd_ptr_i];

endmodule

// File: rtl/bht_update_gen.sv
// bht_update_gen: in-order prediction queue driving BHT/PHT updates; BHT_UPD_STATS_EN adds saturating stat counters
module bht_update_gen import bpu_pkg::*; #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = BPU_ADDR_W,
    parameter int HIST_W = BPU_HIST_W
) (
    input logic              clk,
    input logic              rst,
    bht_update_gen_if.slave  bus_io
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              ready, push, pop, miss, under;
    bpu_entry_t        wr_entry, head;
    logic              update_valid_q, real_direct_q, pred_true_q, pred_flag_q, flush_req_q, underflow_q;
    logic [ADDR_W-1:0] update_addr_q;
    logic [HIST_W-1:0] update_bhr_q;

    assign ready    = count_q != CW'(DEPTH);
    assign push     = bus_io.pred_valid && ready && !bus_io.stallreq;
    assign pop      = bus_io.ex_valid && count_q != '0 && !bus_io.stallreq;
    assign miss     = pop && head.pred_direct != bus_io.ex_real_direct;
    assign under    = bus_io.ex_valid && count_q == '0 && !bus_io.stallreq;
    assign wr_entry = '{addr: bus_io.pred_addr, bhr: bus_io.pred_bhr, pred_direct: bus_io.pred_direct};

    // a push racing a mispredict is wrong-path, so it is neither stored nor counted
    bpu_queue_mem #(.DEPTH(DEPTH)) u_mem (
        .clk      (clk),
        .we_i     (push && !miss),
        .wr_ptr_i (wr_ptr_q),
        .wdata_i  (wr_entry),
        .rd_ptr_i (rd_ptr_q),
        .rdata_o  (head)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push && !miss);
        rd_ptr_d = miss ? wr_ptr_q : rd_ptr_q + PW'(pop);
        count_d  = miss ? '0 : count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            update_valid_q <= 1'b0;
            update_addr_q  <= '0;
            update_bhr_q   <= '0;
            real_direct_q  <= 1'b0;
            pred_true_q    <= 1'b0;
            pred_flag_q    <= 1'b0;
            flush_req_q    <= 1'b0;
            underflow_q    <= 1'b0;
        end else if (!bus_io.stallreq) begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            update_valid_q <= pop;
            pred_true_q    <= pop && !miss;
            pred_flag_q    <= miss;
            flush_req_q    <= miss;
            underflow_q    <= under;
            if (pop) begin
                update_addr_q <= head.addr;
                update_bhr_q  <= bpu_shift_hist(head.bhr, bus_io.ex_real_direct);
                real_direct_q <= bus_io.ex_real_direct;
            end
        end
    end

`ifdef BHT_UPD_STATS_EN
    logic [15:0] stat_total_q, stat_miss_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_total_q <= '0;
            stat_miss_q  <= '0;
        end else if (!bus_io.stallreq) begin
            if (pop && stat_total_q != 16'hFFFF) stat_total_q <= stat_total_q + 16'd1;
            if (miss && stat_miss_q != 16'hFFFF) stat_miss_q <= stat_miss_q + 16'd1;
        end
    end

    assign bus_io.stat_total = stat_total_q;
    assign bus_io.stat_miss  = stat_miss_q;
`else
    assign bus_io.stat_total = '0;
    assign bus_io.stat_miss  = '0;
`endif

    assign bus_io.pred_ready   = ready;
    assign bus_io.count        = count_q;
    assign bus_io.update_valid = update_valid_q;
    assign bus_io.update_addr  = update_addr_q;
    assign bus_io.update_bhr   = update_bhr_q;
    assign bus_io.real_direct  = real_direct_q;
    assign bus_io.pred_true    = pred_true_q;
    assign bus_io.pred_flag    = pred_flag_q;
    assign bus_io.flush_req    = flush_req_q;
    assign bus_io.underflow    = underflow_q;

endmodule

// File: tb/tb_bht_update_gen.sv
// tb_bht_update_gen: queue-model scoreboard bench with directed and random stimulus
module tb_bht_update_gen;

    localparam int DEPTH = 8;
    localparam int AW    = 6;
    localparam int HW    = 4;
`ifdef BHT_UPD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct packed {
        logic [AW-1:0] a;
        logic [HW-1:0] b;
        logic          d;
    } ent_t;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [HW-1:0] b;
        logic          rd;
        logic          t;
    } upd_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bht_update_gen_if #(.DEPTH(DEPTH), .ADDR_W(AW), .HIST_W(HW)) bus ();

    bht_update_gen #(.DEPTH(DEPTH), .ADDR_W(AW), .HIST_W(HW)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    int   errors = 0;
    int   checks = 0;
    ent_t mq[$];
    upd_t sb[$];
    logic m_under = 1'b0;
    int   m_total = 0;
    int   m_miss  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // one clock of stimulus: model is advanced from the state seen before the edge
    task automatic cycle(input logic r, input logic s, input logic pv, input logic [AW-1:0] pa,
                         input logic [HW-1:0] pb, input logic pd, input logic ev, input logic ed);
        int   sz;
        upd_t e;
        ent_t n;
        rst = r;
        bus.stallreq = s;
        bus.pred_valid = pv;
        bus.pred_addr = pa;
        bus.pred_bhr = pb;
        bus.pred_direct = pd;
        bus.ex_valid = ev;
        bus.ex_real_direct = ed;
        #1;
        sz = mq.size();
        n = '{a: pa, b: pb, d: pd};
        chk("pred_ready", {31'd0, bus.pred_ready}, {31'd0, sz < DEPTH});
        if (r) begin
            mq.delete();
            m_under = 1'b0;
            m_total = 0;
            m_miss = 0;
        end else if (!s) begin
            m_under = ev && sz == 0;
            if (ev && sz > 0) begin
                e.a = mq[0].a;
                e.b = HW'((int'(mq[0].b) * 2 + int'(ed)) % (1 << HW));
                e.rd = ed;
                e.t = mq[0].d == ed;
                sb.push_back(e);
                void'(mq.pop_front());
                if (STATS) begin
                    m_total = m_total < 65535 ? m_total + 1 : m_total;
                    if (!e.t) m_miss = m_miss < 65535 ? m_miss + 1 : m_miss;
                end
                if (!e.t) mq.delete();
                else if (pv && sz < DEPTH) mq.push_back(n);
            end else if (pv && sz < DEPTH) begin
                mq.push_back(n);
            end
        end
        @(posedge clk);
        #1;
        chk("count", 32'(bus.count), 32'(mq.size()));
        chk("underflow", {31'd0, bus.underflow}, {31'd0, m_under});
        chk("stat_total", 32'(bus.stat_total), 32'(m_total));
        chk("stat_miss", 32'(bus.stat_miss), 32'(m_miss));
        if (r) begin
            chk("rst_update_valid", {31'd0, bus.update_valid}, 0);
            chk("rst_update_addr", 32'(bus.update_addr), 0);
            chk("rst_update_bhr", 32'(bus.update_bhr), 0);
            chk("rst_real_direct", {31'd0, bus.real_direct}, 0);
            chk("rst_flags", {29'd0, bus.pred_true, bus.pred_flag, bus.flush_req}, 0);
        end
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [HW-1:0] b, input logic d);
        cycle(1'b0, 1'b0, 1'b1, a, b, d, 1'b0, 1'b0);
    endtask

    task automatic resolve(input logic ed);
        cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, ed);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic reset();
        cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin : monitor
        logic s, r;
        upd_t e;
        forever begin
            @(posedge clk);
            s = bus.stallreq;
            r = rst;
            @(negedge clk);
            if (!r && !s) begin
                if (bus.update_valid) begin
                    if (sb.size() == 0) begin
                        chk("spurious_update", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("update_addr", 32'(bus.update_addr), 32'(e.a));
                        chk("update_bhr", 32'(bus.update_bhr), 32'(e.b));
                        chk("real_direct", {31'd0, bus.real_direct}, {31'd0, e.rd});
                        chk("pred_true", {31'd0, bus.pred_true}, {31'd0, e.t});
                        chk("pred_flag", {31'd0, bus.pred_flag}, {31'd0, !e.t});
                        chk("flush_req", {31'd0, bus.flush_req}, {31'd0, !e.t});
                    end
                end else begin
                    chk("idle_flags", {29'd0, bus.pred_true, bus.pred_flag, bus.flush_req}, 0);
                end
            end
        end
    end

    initial begin
        reset();
        reset();
        push(6'd5, 4'b0011, 1'b1);
        push(6'd9, 4'b0011, 1'b1);
        push(6'd12, 4'b0011, 1'b1);
        resolve(1'b1);
        resolve(1'b1);
        resolve(1'b1);
        idle();
        chk("three_updates_bhr", 32'(bus.update_bhr), 32'b0111);
        push(6'd7, 4'b1010, 1'b1);
        push(6'd20, 4'b0001, 1'b0);
        push(6'd21, 4'b0110, 1'b1);
        resolve(1'b0);
        chk("mispredict_flush", {31'd0, bus.flush_req}, 1);
        chk("mispredict_bhr", 32'(bus.update_bhr), 32'b0100);
        idle();
        chk("flush_count_zero", 32'(bus.count), 0);
        for (int i = 0; i < DEPTH; i++) push(6'(30 + i), 4'(i), 1'b1);
        push(6'd50, 4'd0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 6'd51, 4'd1, 1'b1, 1'b1, 1'b1);
        push(6'd52, 4'd2, 1'b1);
        for (int i = 0; i < DEPTH; i++) resolve(1'b1);
        idle();
        resolve(1'b0);
        resolve(1'b1);
        idle();
        push(6'd40, 4'b1100, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 6'd41, 4'b0101, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 6'd41, 4'b0101, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        resolve(1'b1);
        idle();
        reset();
        for (int i = 0; i < 10; i++) begin
            push(6'(i), 4'(i), 1'b1);
            resolve(!(i % 3 == 0 && i < 9));
        end
        idle();
        chk("stat_total_10", 32'(bus.stat_total), STATS ? 10 : 0);
        chk("stat_miss_3", 32'(bus.stat_miss), STATS ? 3 : 0);
        push(6'd3, 4'd3, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 6'd4, 4'd4, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(199) == 0, $urandom_range(7) == 0, 1'($urandom), 6'($urandom), 4'($urandom),
                  1'($urandom), $urandom_range(2) == 0, 1'($urandom));
        idle();
        idle();
        chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bht_update_gen.md
# bht_update_gen

Branch-update generator for the two-level branch predictor: the producer side of the BHT/PHT update interface. At predict time, each prediction's hashed BHT index, history snapshot and predicted direction are queued in program order. When the execute stage resolves a branch, the oldest entry is popped, checked against the real direction, and driven as a registered update (`update_valid`, `update_addr`, `update_bhr`, `real_direct`, `pred_true`, `pred_flag`) into the BHT/PHT. On a mispredict it flushes all younger speculative entries and raises a flush request to fetch.

## Interface
- `DEPTH`, 8: queue entries; power of two, 2..32.
- `ADDR_W`, 6: BHT index width.
- `HIST_W`, 4: branch history width.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous reset, active-high.
- `stallreq`  in  1  pipeline stall: all state and outputs hold.
- `pred_valid`  in  1  fetch pushes one prediction.
- `pred_addr`  in  ADDR_W  hashed BHT index of the branch.
- `pred_bhr`  in  HIST_W  BHR read at prediction.
- `pred_direct`  in  1  predicted direction (1 = taken).
- `pred_ready`  out  1  queue not full (combinational from count).
- `ex_valid`  in  1  execute resolves the oldest outstanding branch.
- `ex_real_direct`  in  1  resolved direction.
- `update_valid`  out  1  registered update strobe.
- `update_addr`  out  ADDR_W  BHT index to update.
- `update_bhr`  out  HIST_W  new history, `{bhr[HIST_W-2:0], real_direct}`.
- `real_direct`  out  1  resolved direction.
- `pred_true`  out  1  update with correct prediction.
- `pred_flag`  out  1  update with mispredict.
- `flush_req`  out  1  one-cycle pulse, same cycle as `pred_flag`.
- `underflow`  out  1  one-cycle pulse: `ex_valid` while empty.
- `count`  out  $clog2(DEPTH)+1  occupancy.
- `stat_total`, `stat_miss`  out  16 each  statistics (see Configuration).

## Operation
- Circular queue with `wr_ptr`, `rd_ptr` (log2 DEPTH bits, natural wrap) and `count`.
- Push: `pred_valid && pred_ready` writes `{pred_addr, pred_bhr, pred_direct}` at `wr_ptr` and increments it. A push while full is dropped; state is unchanged.
- Resolve: `ex_valid && count!=0` pops the head. The outputs are registered from the head entry. `pred_true` = (head.pred_direct == ex_real_direct). `pred_flag` is its inverse. `pred_true` and `pred_flag` are never both 1, and both are 0 when `update_valid` is 0.
- Mispredict: in the pop cycle, `rd_ptr <= wr_ptr` and `count <= 0`. A push in the same cycle is discarded, because it is on the wrong path.
- Push and correct pop in the same cycle: `count` is unchanged and both pointers advance. Full with a simultaneous pop still rejects the push, because `pred_ready` is based on the current count.
- `ex_valid` while empty: no pop, no update; `underflow` pulses.
- `stallreq` overrides push, pop and pulse generation. Registered outputs hold their previous values. `update_valid` is **not** re-issued: a stall in the cycle after an update holds `update_valid` high, and the BHT ignores it under stall.
- Reset: pointers, `count`, `update_valid`, `pred_true`, `pred_flag`, `flush_req`, `underflow`, `update_addr`, `update_bhr`, `real_direct` and the stat counters all go to 0. Reset overrides a simultaneous push or pop, and there is no partial commit.

## Timing
- Push to visible in `count`: 1 cycle.
- Resolve to `update_valid`/`pred_flag`/`flush_req`: 1 cycle (registered).
- Back-to-back resolves produce one update per cycle.
- `pred_ready` is combinational from `count` only, with no path from the inputs.

## Configuration
- `BHT_UPD_STATS_EN` defined:
  - `stat_total` increments on every update.
  - `stat_miss` increments on every mispredict.
  - Both are 16-bit, saturate at 16'hFFFF, clear on reset and hold under stall.
- `BHT_UPD_STATS_EN` undefined: `stat_total` and `stat_miss` are tied to 0 and no counter flops are inferred.

## Structure
- Package `bpu_pkg`:
  - `bpu_entry_t` struct `{addr, bhr, pred_direct}`.
  - Constants `BPU_ADDR_W=6`, `BPU_HIST_W=4`.
  - Function `bpu_shift_hist(bhr, dir)`.
- Sub-module `bpu_queue_mem`: DEPTH×entry register array with one write port and a combinational read of the head. Pointer and count logic stay in the top.

## Test plan
- Reset, then push three entries (addr 5/9/12, bhr 4'b0011, pred 1) and resolve taken ×3 -> three updates on consecutive cycles, each `pred_true=1`, `update_bhr=4'b0111`, `count` ends at 0.
- Push addr 7 / bhr 4'b1010 / pred 1 plus two younger entries, then resolve not-taken -> `pred_flag=1`, `flush_req=1`, `update_bhr=4'b0100`, next cycle `count=0`, `pred_ready=1`.
- Fill 8 entries, then push a 9th -> dropped, `pred_ready=0`; one pop later the next push is accepted and wrap-around order is preserved (addresses pop in push order).
- `ex_valid` while empty -> `underflow` pulses for one cycle, `update_valid=0`, `count` stays 0.
- `stallreq` asserted together with push and resolve -> no state change; after release the same stimulus produces the update one cycle later.
- With `BHT_UPD_STATS_EN`: 10 resolves, 3 of them mispredicts -> `stat_total=10`, `stat_miss=3`; `rst` mid-run clears both in the same cycle and the update outputs go to 0.
